// File: rtl/regfile_sb.sv
// Parametrised integer register file with a per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through to the read ports.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_idx,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [NRD*AW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_idx,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic [AW:0]      cnt_next;
    logic             wr_ok;
    logic             rsv_ok;

    // Register 0 is hardwired: writes and reserves to it are discarded.
    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_idx  == '0));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_idx == '0));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pending_next = pending;
        if (flush) begin
            pending_next = '0;
        end
        if (wr_ok) begin
            pending_next[wr_idx] = 1'b0;
        end
        // Applied last so a new producer outranks the flush and the same-edge writeback.
        if (rsv_ok) begin
            pending_next[rsv_idx] = 1'b1;
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_next = cnt_next + {{AW{1'b0}}, pending_next[i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array itself is cleared here because reads after reset must return 0.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending  <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok) begin
                regs[wr_idx] <= wr_data;
            end
            pending  <= pending_next;
            busy_cnt <= cnt_next;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0] idx;
            idx = rd_idx[p*AW +: AW];
            if ((ZERO_REG != 0) && (idx == '0)) begin
                rd_data[p*XLEN +: XLEN] = '0;
                rd_busy[p]              = 1'b0;
            end else begin
                rd_data[p*XLEN +: XLEN] = regs[idx];
                rd_busy[p]              = pending[idx];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (wr_idx == idx)) begin
                    rd_data[p*XLEN +: XLEN] = wr_data;
                    // A same-cycle reserve of this index keeps the register marked busy.
                    if (!(rsv_ok && (rsv_idx == idx))) begin
                        rd_busy[p] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb (default parameters, two read ports).
// Also exercises reset mid-operation and the REGFILE_BYPASS_EN read path when defined.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int AW = 5;

    logic                clk;
    logic                rst;
    logic                wr_en;
    logic [AW-1:0]       wr_idx;
    logic [XLEN-1:0]     wr_data;
    logic [NRD*AW-1:0]   rd_idx;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                rsv_en;
    logic [AW-1:0]       rsv_idx;
    logic                flush;
    logic [AW:0]         busy_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
        .rsv_en(rsv_en), .rsv_idx(rsv_idx), .flush(flush), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            wr_en;
        logic [AW-1:0]   wr_idx;
        logic [XLEN-1:0] wr_data;
        logic            rsv_en;
        logic [AW-1:0]   rsv_idx;
        logic            flush;
        logic [AW-1:0]   ra;
        logic [AW-1:0]   rb;
        logic [XLEN-1:0] ea;
        logic [XLEN-1:0] eb;
        logic            busy_a;
        logic            busy_b;
        logic [AW:0]     cnt;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [XLEN-1:0] actual,
                         input logic [XLEN-1:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_idx = '0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ports(input string tag, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                               input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb,
                               input logic busy_a, input logic busy_b);
        rd_idx = {rb, ra};
        #1;
        check({tag, " data0"}, rd_data[0 +: XLEN], ea);
        check({tag, " data1"}, rd_data[XLEN +: XLEN], eb);
        check({tag, " busy0"}, {31'b0, rd_busy[0]}, {31'b0, busy_a});
        check({tag, " busy1"}, {31'b0, rd_busy[1]}, {31'b0, busy_b});
    endtask

    initial begin
        //          rst wr  widx wdata         rsv ridx flush ra  rb  ea            eb            ba bb cnt
        vecs[0]  = '{0, 1, 1,  32'h0000_0011, 0, 0,  0,    1,  0,  32'h0000_0011, 32'h0,        0, 0, 0};
        vecs[1]  = '{0, 0, 0,  32'h0,         1, 7,  0,    7,  1,  32'h0,         32'h0000_0011, 1, 0, 1};
        vecs[2]  = '{0, 1, 7,  32'h1234_5678, 0, 0,  0,    7,  7,  32'h1234_5678, 32'h1234_5678, 0, 0, 0};
        vecs[3]  = '{0, 1, 3,  32'hDEAD_BEEF, 1, 3,  0,    3,  7,  32'hDEAD_BEEF, 32'h1234_5678, 1, 0, 1};
        vecs[4]  = '{0, 1, 0,  32'hFFFF_FFFF, 1, 0,  0,    0,  3,  32'h0,         32'hDEAD_BEEF, 0, 1, 1};
        vecs[5]  = '{0, 0, 0,  32'h0,         1, 2,  0,    2,  3,  32'h0,         32'hDEAD_BEEF, 1, 1, 2};
        vecs[6]  = '{0, 0, 0,  32'h0,         1, 4,  0,    4,  2,  32'h0,         32'h0,         1, 1, 3};
        vecs[7]  = '{0, 0, 0,  32'h0,         1, 9,  0,    9,  4,  32'h0,         32'h0,         1, 1, 4};
        vecs[8]  = '{0, 0, 0,  32'h0,         1, 11, 1,    11, 2,  32'h0,         32'h0,         1, 0, 1};
        vecs[9]  = '{0, 0, 0,  32'h0,         1, 11, 0,    11, 3,  32'h0,         32'hDEAD_BEEF, 1, 0, 1};
        vecs[10] = '{0, 1, 11, 32'h0000_00BB, 0, 0,  1,    11, 11, 32'h0000_00BB, 32'h0000_00BB, 0, 0, 0};
        vecs[11] = '{0, 1, 31, 32'hCAFE_F00D, 1, 30, 0,    31, 30, 32'hCAFE_F00D, 32'h0,         0, 1, 1};
        vecs[12] = '{0, 1, 30, 32'h0000_0030, 0, 0,  0,    30, 1,  32'h0000_0030, 32'h0000_0011, 0, 0, 0};
        vecs[13] = '{0, 1, 5,  32'h0000_0055, 1, 5,  1,    5,  5,  32'h0000_0055, 32'h0000_0055, 1, 1, 1};
        vecs[14] = '{1, 1, 1,  32'h0000_0099, 1, 6,  0,    1,  6,  32'h0,         32'h0,         0, 0, 0};

        idle_inputs();
        rd_idx = '0;

        rst = 1'b1;
        tick();
        idle_inputs();
        check_ports("reset", 5'd1, 5'd31, 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset busy_cnt", {26'b0, busy_cnt}, 32'h0);

        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst; wr_en = vecs[i].wr_en; wr_idx = vecs[i].wr_idx;
            wr_data = vecs[i].wr_data; rsv_en = vecs[i].rsv_en; rsv_idx = vecs[i].rsv_idx;
            flush = vecs[i].flush;
            tick();
            idle_inputs();
            check_ports($sformatf("vec%0d", i), vecs[i].ra, vecs[i].rb,
                        vecs[i].ea, vecs[i].eb, vecs[i].busy_a, vecs[i].busy_b);
            check($sformatf("vec%0d busy_cnt", i), {26'b0, busy_cnt}, {26'b0, vecs[i].cnt});
        end

        // Reset in the middle of activity, with a write and reserve asserted in the reset cycle.
        for (int i = 1; i < NREGS; i++) begin
            wr_en = 1'b1; wr_idx = AW'(i); wr_data = 32'hA5A5_0000 + 32'(i);
            rsv_en = (i == 5); rsv_idx = 5'd5;
            tick();
        end
        idle_inputs();
        check_ports("pre-rst", 5'd5, 5'd31, 32'hA5A5_0005, 32'hA5A5_001F, 1'b1, 1'b0);
        check("pre-rst busy_cnt", {26'b0, busy_cnt}, 32'h1);
        rst = 1'b1; wr_en = 1'b1; wr_idx = 5'd8; wr_data = 32'h1111_1111;
        rsv_en = 1'b1; rsv_idx = 5'd8;
        tick();
        idle_inputs();
        for (int i = 0; i < NREGS; i++) begin
            check_ports($sformatf("post-rst r%0d", i), AW'(i), AW'(NREGS - 1 - i),
                        32'h0, 32'h0, 1'b0, 1'b0);
        end
        check("post-rst busy_cnt", {26'b0, busy_cnt}, 32'h0);

        // Read-during-write on r6 from both ports; r6 holds 0x66 and is pending.
        wr_en = 1'b1; wr_idx = 5'd6; wr_data = 32'h0000_0066;
        tick();
        idle_inputs();
        rsv_en = 1'b1; rsv_idx = 5'd6;
        tick();
        idle_inputs();
        check("r6 pending busy_cnt", {26'b0, busy_cnt}, 32'h1);
        wr_en = 1'b1; wr_idx = 5'd6; wr_data = 32'h0000_00C3;
`ifdef REGFILE_BYPASS_EN
        check_ports("bypass", 5'd6, 5'd6, 32'h0000_00C3, 32'h0000_00C3, 1'b0, 1'b0);
        rsv_en = 1'b1; rsv_idx = 5'd6;
        check_ports("bypass+rsv", 5'd6, 5'd6, 32'h0000_00C3, 32'h0000_00C3, 1'b1, 1'b1);
`else
        check_ports("no-bypass", 5'd6, 5'd6, 32'h0000_0066, 32'h0000_0066, 1'b1, 1'b1);
        rsv_en = 1'b1; rsv_idx = 5'd6;
        check_ports("no-bypass+rsv", 5'd6, 5'd6, 32'h0000_0066, 32'h0000_0066, 1'b1, 1'b1);
`endif
        tick();
        idle_inputs();
        check_ports("after wr+rsv r6", 5'd6, 5'd6, 32'h0000_00C3, 32'h0000_00C3, 1'b1, 1'b1);
        check("after wr+rsv busy_cnt", {26'b0, busy_cnt}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
